// File: rtl/alu_scheduler_if.sv
// Request/response bundle between NREQ requesters and the shared ALU scheduler.
// Request side is packed per requester (slice i at [i*W +: W] / [i*4 +: 4]).
// master = requesters plus response consumer, slave = the scheduler itself.
interface alu_scheduler_if #(
    parameter int W    = 64,
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_ctl;

    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_result;
    logic              resp_zero;

    modport master (
        output req_valid, req_a, req_b, req_ctl, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctl, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_zero
    );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational 64-bit ALU among NREQ requesters.
// Latency: result visible one cycle after accept; one accept per cycle sustained.
// Backpressure: one-entry response register; no grant while it is full and not consumed.
// Build option ALU_SCHED_PRIO_EN: requester 0 gets strict priority, others round-robin.
module alu_scheduler #(
    parameter int W    = 64,
    parameter int NREQ = 2      // legal range 2..4
) (
    input  logic          clk,
    input  logic          reset,  // synchronous, active low
    alu_scheduler_if.slave bus
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;

    // Local views of the bundle
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_ctl;
    logic              resp_ready;

    assign req_valid  = bus.req_valid;
    assign req_a      = bus.req_a;
    assign req_b      = bus.req_b;
    assign req_ctl    = bus.req_ctl;
    assign resp_ready = bus.resp_ready;

    // Architectural state
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q,    resp_id_d;
    logic [W-1:0]   resp_result_q, resp_result_d;
    logic           resp_zero_q,  resp_zero_d;
    logic [IDW-1:0] last_ptr_q,   last_ptr_d;

    // Arbitration results
    logic           slot_free;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt_oh;

    // Selected operands and ALU output
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [3:0]     sel_ctl;
    logic [W-1:0]   alu_res;

    // Unknown codes yield the constant one so they can never look like a zero result.
    function automatic logic [W-1:0] alu_eval(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [3:0]   ctl);
        logic [W-1:0] r;
        case (ctl)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_PASSB: r = b;
            default:  r = W'(1);
        endcase
        return r;
    endfunction

    // The register can take a new result if empty or being drained this cycle.
    assign slot_free = !resp_valid_q || resp_ready;

    // Pick the winner: rotating search starting just after the last granted index.
    always_comb begin : arb
        logic [IDW-1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (reset && slot_free) begin
`ifdef ALU_SCHED_PRIO_EN
            if (req_valid[0]) begin
                gnt_any = 1'b1;
                gnt_idx = '0;
            end else begin
                // Index 0 is excluded here; last_ptr only ever tracks indices >= 1.
                for (int k = 1; k <= NREQ; k++) begin
                    cand = IDW'((int'(last_ptr_q) + k) % NREQ);
                    if (!gnt_any && (cand != '0) && req_valid[cand]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
`else
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDW'((int'(last_ptr_q) + k) % NREQ);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
`endif
        end
    end

    // One-hot grant vector doubles as req_ready and as the operand mux select.
    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && (gnt_idx == IDW'(i))) begin
                gnt_oh[i] = 1'b1;
            end
        end
    end

    // Route the granted requester's operands to the ALU.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_ctl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_ctl = req_ctl[i*4 +: 4];
            end
        end
    end

    assign alu_res = alu_eval(sel_a, sel_b, sel_ctl);

    // Next-state: accept overwrites the slot (even when it is drained on the same edge).
    always_comb begin
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        last_ptr_d    = last_ptr_q;
        if (gnt_any) begin
            resp_valid_d  = 1'b1;
            resp_id_d     = gnt_idx;
            resp_result_d = alu_res;
            resp_zero_d   = (alu_res == '0);
`ifdef ALU_SCHED_PRIO_EN
            if (gnt_idx != '0) begin
                last_ptr_d = gnt_idx;
            end
`else
            last_ptr_d = gnt_idx;
`endif
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending response and re-arms requester 0 first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            last_ptr_q    <= PTR_RST;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            last_ptr_q    <= last_ptr_d;
        end
    end

    assign bus.req_ready   = gnt_oh;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_zero   = resp_zero_q;

    // At most one requester is ever granted.
    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt_oh));

    // A stalled response must not change until it is consumed.
    a_stall_hold: assert property (@(posedge clk) disable iff (!reset)
        (resp_valid_q && !resp_ready) |=>
            (resp_valid_q && $stable(resp_result_q) && $stable(resp_id_q) && $stable(resp_zero_q)));
endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed test-plan sequences plus random traffic.
// A transaction-level model predicts grants and the response register every cycle.
// Compare process samples on the falling edge; stimulus changes 1 time unit after rising edge.
module tb_alu_scheduler;
    localparam int W    = 64;
    localparam int NREQ = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_scheduler_if #(.W(W), .NREQ(NREQ)) bus();

    alu_scheduler #(.W(W), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] c);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return b;
            default: return 64'd1;
        endcase
    endfunction

    // Returns the index that must be granted, or -1 for none.
    function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr,
                                     input bit free, input bit rst_n);
        if (!rst_n || !free) return -1;
`ifdef ALU_SCHED_PRIO_EN
        if (v[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (j != 0 && v[j]) return j;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j]) return j;
        end
`endif
        return -1;
    endfunction

    bit          m_init = 1'b0;
    bit          m_valid;
    bit          m_zero;
    logic [W-1:0] m_result;
    int          m_id;
    int          m_ptr;
    bit          m_acc [NREQ];

    // Model register update at each rising edge
    always @(posedge clk) begin : model
        int g;
        g = ref_grant(bus.req_valid, m_ptr, !m_valid || bus.resp_ready, reset);
        for (int i = 0; i < NREQ; i++) m_acc[i] = 1'b0;
        if (!reset) begin
            m_init   = 1'b1;
            m_valid  = 1'b0;
            m_id     = 0;
            m_result = '0;
            m_zero   = 1'b0;
            m_ptr    = NREQ - 1;
        end else if (m_init) begin
            if (g >= 0) begin
                m_result = ref_alu(bus.req_a[g*W +: W], bus.req_b[g*W +: W], bus.req_ctl[g*4 +: 4]);
                m_zero   = (m_result == 0);
                m_id     = g;
                m_valid  = 1'b1;
                m_acc[g] = 1'b1;
`ifdef ALU_SCHED_PRIO_EN
                if (g >= 1) m_ptr = g;
`else
                m_ptr = g;
`endif
            end else if (m_valid && bus.resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin : cmp
        int g;
        logic [NREQ-1:0] exp_rdy;
        if (m_init) begin
            g = ref_grant(bus.req_valid, m_ptr, !m_valid || bus.resp_ready, reset);
            exp_rdy = '0;
            for (int i = 0; i < NREQ; i++) if (i == g) exp_rdy[i] = 1'b1;
            chk("req_ready",   64'(bus.req_ready),  64'(exp_rdy));
            chk("resp_valid",  64'(bus.resp_valid), 64'(m_valid));
            chk("resp_id",     64'(bus.resp_id),    64'(m_id));
            chk("resp_result", bus.resp_result,     m_result);
            chk("resp_zero",   64'(bus.resp_zero),  64'(m_zero));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] c);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*W +: W]    = a;
        bus.req_b[i*W +: W]    = b;
        bus.req_ctl[i*4 +: 4]  = c;
    endtask

    // Single-requester op starting at posedge+1; checks grant then the registered result.
    task automatic op(input string nm, input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] c, input logic [W-1:0] er, input bit ez);
        logic [NREQ-1:0] m;
        m = '0;
        m[i] = 1'b1;
        bus.req_valid = '0;
        set_req(i, a, b, c);
        #1;
        chk({nm, "_rdy"}, 64'(bus.req_ready), 64'(m));
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk({nm, "_vld"},  64'(bus.resp_valid), 64'd1);
        chk({nm, "_res"},  bus.resp_result,     er);
        chk({nm, "_zero"}, 64'(bus.resp_zero),  64'(ez));
        chk({nm, "_id"},   64'(bus.resp_id),    64'(i));
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_ctl();
        logic [3:0] tbl [5];
        int p;
        tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
        p = $urandom_range(0, 7);
        if (p < 5) return tbl[p];
        return 4'($urandom_range(0, 15));
    endfunction

    logic [W-1:0] exp_res_id [NREQ];
    int           exp_id;

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_ctl    = '0;
        bus.resp_ready = 1'b1;
        reset          = 1'b0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 64'(bus.resp_valid),  64'd0);
        chk("rst_res", bus.resp_result,      64'd0);
        chk("rst_rdy", 64'(bus.req_ready),   64'd0);
        reset = 1'b1;

        // Single op and opcode sweep
        op("sub5_3",  0, 64'd5,    64'd3,    4'b0110, 64'd2,    1'b0);
        op("and",     1, 64'hF0,   64'h0F,   4'b0000, 64'd0,    1'b1);
        op("or",      1, 64'hF0,   64'h0F,   4'b0001, 64'hFF,   1'b0);
        op("add",     1, 64'hF0,   64'h0F,   4'b0010, 64'hFF,   1'b0);
        op("passb",   1, 64'hF0,   64'h0F,   4'b0111, 64'h0F,   1'b0);
        op("badop",   1, 64'hF0,   64'h0F,   4'b1111, 64'd1,    1'b0);
        op("sub7_7",  1, 64'd7,    64'd7,    4'b0110, 64'd0,    1'b1);
        op("addwrap", 0, '1,       64'd1,    4'b0010, 64'd0,    1'b1);
        op("subwrap", 1, 64'd0,    64'd1,    4'b0110, '1,       1'b0);

        // Fairness: both held valid, last grant was requester 1
        exp_res_id[0] = 64'd101;
        exp_res_id[1] = 64'd202;
        set_req(0, 64'd100, 64'd1, 4'b0010);
        set_req(1, 64'd200, 64'd2, 4'b0010);
        exp_id = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
`ifdef ALU_SCHED_PRIO_EN
            exp_id = 0;
`else
            exp_id = k % 2;
`endif
            chk("fair_vld", 64'(bus.resp_valid), 64'd1);
            chk("fair_id",  64'(bus.resp_id),    64'(exp_id));
            chk("fair_res", bus.resp_result,     exp_res_id[exp_id]);
        end

        // Backpressure for three cycles with both requesters still valid
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rdy", 64'(bus.req_ready), 64'd0);
            @(posedge clk); #1;
            chk("bp_vld", 64'(bus.resp_valid), 64'd1);
            chk("bp_id",  64'(bus.resp_id),    64'(exp_id));
            chk("bp_res", bus.resp_result,     exp_res_id[exp_id]);
        end
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_release_vld", 64'(bus.resp_valid), 64'd1);
        chk("bp_release_id",  64'(bus.resp_id),    64'd0);
        chk("bp_release_res", bus.resp_result,     64'd101);

        // Reset while a response is stalled
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        chk("stall_vld", 64'(bus.resp_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_rdy", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rstmid_vld", 64'(bus.resp_valid), 64'd0);
        chk("rstmid_res", bus.resp_result,     64'd0);
        bus.resp_ready = 1'b1;
        #1;
        chk("rstmid_next_rdy", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        chk("rstmid_next_id", 64'(bus.resp_id), 64'd0);
        bus.req_valid = '0;

        // Random traffic; held requests keep their payload until the model sees them accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            reset          = ($urandom_range(0, 199) != 0);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc[i] || !bus.req_valid[i]) begin
                    bus.req_valid[i] = 1'b0;
                    if ($urandom_range(0, 3) != 0) set_req(i, rnd_op(), rnd_op(), rnd_ctl());
                end
            end
        end

        // Drain
        @(posedge clk); #1;
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("final_vld", 64'(bus.resp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares one 64-bit integer ALU between NREQ requesters, e.g. the execute stage and an address-generation helper.
- Arbitrates round-robin and accepts at most one operation per cycle.
- Evaluates the operation combinationally and holds the result in a one-entry response register, with valid/ready handshakes on both sides.
- Sits between the requesters and the shared ALU. No other path into the ALU exists.

Parameters:
- W, 64: operand and result width.
- NREQ, 2: number of requesters. Legal range is 2..4.
- IDW (localparam): max(1, $clog2(NREQ)). Width of the requester ID.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous active-low reset (0 = reset).
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (grant).
- req_a  in  NREQ*W  packed operand A; requester i occupies slice [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same slicing.
- req_ctl  in  NREQ*4  packed ALU control code, slice [i*4 +: 4].
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  downstream consumes the response.
- resp_id  out  IDW  index of the requester that produced the response.
- resp_result  out  W  ALU result.
- resp_zero  out  1  1 when resp_result == 0.

Behaviour:
- ALU codes:
  - 0000 = A&B
  - 0001 = A|B
  - 0010 = A+B (mod 2^W)
  - 0110 = A-B (mod 2^W)
  - 0111 = B
  - any other code gives result = 1 (value one, zero-extended), so resp_zero = 0.
- Slot free condition: slot_free = !resp_valid || resp_ready.
- Grant:
  - When slot_free, exactly one valid requester is granted: the first valid index searching from (last_ptr+1) mod NREQ upward with wrap.
  - req_ready[i] = 1 only for the granted index. All bits are 0 when slot_free = 0 or no request is valid.
  - req_ready is combinational from req_valid, resp_valid, resp_ready and last_ptr.
  - Requesters must not make req_valid depend on req_ready.
- Accept: an accept occurs when req_valid[i] && req_ready[i]. On that edge:
  - resp_result <= ALU(a_i, b_i, ctl_i); resp_zero <= (that result == 0).
  - resp_id <= i; resp_valid <= 1; last_ptr <= i.
- Latency: the result is visible one cycle after accept. Back-to-back throughput is 1 per cycle while resp_ready stays high.
- Drain: when resp_ready && resp_valid and there is no accept on that edge, resp_valid <= 0.
  - Consume and accept on the same edge: the new result replaces the old one and resp_valid stays 1.
- Stall: when resp_valid && !resp_ready, all response outputs hold stable and every req_ready bit is 0.
- Request stability: a requester that is not granted must hold a, b and ctl stable until it is accepted.
- Pointer: last_ptr changes only on accept. Idle cycles leave it unchanged.
- Reset values (reset = 0 at an edge):
  - resp_valid = 0, resp_id = 0, resp_result = 0, resp_zero = 0.
  - last_ptr = NREQ-1, so requester 0 wins first.
- Reset mid-operation: any pending response is discarded. req_ready is forced to 0 in every cycle where reset = 0.
- Fairness: with all requesters continuously valid and resp_ready = 1, grants rotate 0,1,...,NREQ-1,0,...

Optional Feature:
- Macro: ALU_SCHED_PRIO_EN.
- Defined: requester 0 has strict priority and is granted whenever req_valid[0] && slot_free. The remaining requesters arbitrate round-robin among themselves using last_ptr. last_ptr is updated only by grants to indices ≥ 1.
- Not defined: pure round-robin across all NREQ requesters, exactly as described in Behaviour.

Test Plan:
- Reset, then single op: assert reset = 0 for 2 cycles, then reset = 1. Requester 0 sends a = 5, b = 3, ctl = 0110. Required: req_ready[0] = 1 in that cycle; next cycle resp_valid = 1, resp_result = 2, resp_zero = 0, resp_id = 0.
- Opcode sweep: requester 1 sends a = 0xF0, b = 0x0F with ctl = 0000 / 0001 / 0010 / 0111 / 1111. Required results: 0 with resp_zero = 1; 0xFF; 0xFF; 0x0F; 1. Check that ctl = 0110 with a = b = 7 gives 0 and resp_zero = 1.
- Wrap-around: a = 2^64-1, b = 1, ctl = 0010 gives result 0 and resp_zero = 1. a = 0, b = 1, ctl = 0110 gives result 0xFFFF_FFFF_FFFF_FFFF.
- Fairness: both requesters held valid and resp_ready = 1 for 6 cycles. Required resp_id sequence: 0,1,0,1,0,1, with one accept per cycle. With ALU_SCHED_PRIO_EN defined: all six are 0.
- Backpressure: resp_ready = 0 for 3 cycles while both requesters are valid. Required: req_ready = 00 and the response outputs hold. When resp_ready rises, consume and a new accept happen on the same edge, and resp_valid stays 1.
- Reset mid-stall: resp_valid = 1, resp_ready = 0, then reset = 0 for 1 cycle. Required: next cycle resp_valid = 0, resp_result = 0, and the next grant goes to requester 0.
